// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared pipeline-control types and default parameter values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_MC_WAIT = 2'd2,
        ST_HALT    = 2'd3
    } pipe_state_t;

    localparam int unsigned MC_TIMEOUT_DEF = 64;
    localparam int unsigned CNT_W_DEF      = 16;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that holds at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline hazard/stall controller with multicycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_stall_2clk_i,
    input  logic             ld_stall_1clk_i,
    input  logic             redirect_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             flush_d_o,
    output logic             bubble_e_o,
    output logic [1:0]       state_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned        WDG_W      = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WDG_W-1:0]   C_WDG_LAST = WDG_W'(MC_TIMEOUT - 1);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic [WDG_W-1:0] r_wdg;
    logic             r_mc_timeout;
    logic             w_wdg_expire;
    logic             w_stall_f;
    logic             w_stall_d;
    logic             w_stall_e;
    logic             w_flush_d;
    logic             w_bubble_e;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_e    = 1'b0;
        w_flush_d    = 1'b0;
        w_bubble_e   = 1'b0;
        w_wdg_expire = 1'b0;
        case (r_state)
            ST_RUN: begin
                // A redirect squashes the wrong-path load, so its hazard is moot.
                if (redirect_i) begin
                    w_flush_d  = 1'b1;
                    w_bubble_e = 1'b1;
                end else if (ld_stall_2clk_i || ld_stall_1clk_i) begin
                    w_stall_f  = 1'b1;
                    w_stall_d  = 1'b1;
                    w_bubble_e = 1'b1;
                end
                if (mc_start_i) begin
                    w_next_state = ST_MC_WAIT;
                end else if (!redirect_i && ld_stall_2clk_i) begin
                    w_next_state = ST_LD_WAIT;
                end else if (!redirect_i && !ld_stall_1clk_i && halt_req_i) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_LD_WAIT: begin
                w_stall_f    = 1'b1;
                w_stall_d    = 1'b1;
                w_bubble_e   = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_MC_WAIT: begin
                if (mc_done_i) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_stall_e = 1'b1;
                    if (r_wdg == C_WDG_LAST) begin
                        w_wdg_expire = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                w_stall_f  = 1'b1;
                w_stall_d  = 1'b1;
                w_bubble_e = 1'b1;
                if (resume_i) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
        if (rst_i) begin
            w_stall_f    = 1'b0;
            w_stall_d    = 1'b0;
            w_stall_e    = 1'b0;
            w_flush_d    = 1'b0;
            w_bubble_e   = 1'b0;
            w_wdg_expire = 1'b0;
        end
    end

    // Held at zero outside MC_WAIT so every entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != ST_MC_WAIT)) begin
            r_wdg <= '0;
        end else if (!mc_done_i) begin
            r_wdg <= r_wdg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mc_timeout <= 1'b0;
        end else if (w_wdg_expire) begin
            r_mc_timeout <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_inc   (w_stall_f),
        .o_count (stall_cnt_o)
    );

    assign stall_f_o    = w_stall_f;
    assign stall_d_o    = w_stall_d;
    assign stall_e_o    = w_stall_e;
    assign flush_d_o    = w_flush_d;
    assign bubble_e_o   = w_bubble_e;
    assign state_o      = r_state;
    assign mc_timeout_o = r_mc_timeout;

endmodule : pipe_ctrl

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed, table-driven self-checking bench for pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       ld_stall_2clk_i = 1'b0;
    logic       ld_stall_1clk_i = 1'b0;
    logic       redirect_i = 1'b0;
    logic       mc_start_i = 1'b0;
    logic       mc_done_i = 1'b0;
    logic       halt_req_i = 1'b0;
    logic       resume_i = 1'b0;
    logic       stall_f_o, stall_d_o, stall_e_o, flush_d_o, bubble_e_o;
    logic [1:0] state_o;
    logic       mc_timeout_o;
    logic [3:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MC_TIMEOUT (8),
        .CNT_W      (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ld_stall_2clk_i (ld_stall_2clk_i),
        .ld_stall_1clk_i (ld_stall_1clk_i),
        .redirect_i      (redirect_i),
        .mc_start_i      (mc_start_i),
        .mc_done_i       (mc_done_i),
        .halt_req_i      (halt_req_i),
        .resume_i        (resume_i),
        .stall_f_o       (stall_f_o),
        .stall_d_o       (stall_d_o),
        .stall_e_o       (stall_e_o),
        .flush_d_o       (flush_d_o),
        .bubble_e_o      (bubble_e_o),
        .state_o         (state_o),
        .mc_timeout_o    (mc_timeout_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    // {stall_f, stall_d, stall_e, flush_d, bubble_e}
    typedef struct packed {
        logic       redir;
        logic       ld2;
        logic       ld1;
        logic       mcs;
        logic       halt;
        logic [4:0] exp_out;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        ld_stall_2clk_i = 1'b0;
        ld_stall_1clk_i = 1'b0;
        redirect_i      = 1'b0;
        mc_start_i      = 1'b0;
        mc_done_i       = 1'b0;
        halt_req_i      = 1'b0;
        resume_i        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    function automatic logic [4:0] outs();
        return {stall_f_o, stall_d_o, stall_e_o, flush_d_o, bubble_e_o};
    endfunction

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11001, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00011, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11001, 2'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 2'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11001, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00011, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11001, 2'd1};

        // Reset: outputs forced low even with a hazard asserted.
        #1;
        rst_i = 1'b1;
        ld_stall_2clk_i = 1'b1;
        #1;
        chk("rst_outs", 32'(outs()), 32'h0);
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_tmo", 32'(mc_timeout_o), 32'd0);
        rst_i = 1'b0;
        clr_in();

        // RUN-state decode table.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            redirect_i      = vecs[i].redir;
            ld_stall_2clk_i = vecs[i].ld2;
            ld_stall_1clk_i = vecs[i].ld1;
            mc_start_i      = vecs[i].mcs;
            halt_req_i      = vecs[i].halt;
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
            tick();
            clr_in();
            chk($sformatf("vec%0d_next", i), 32'(state_o), 32'(vecs[i].exp_st));
        end

        // Two-cycle load-use stall.
        do_reset();
        ld_stall_2clk_i = 1'b1;
        #1;
        chk("ld2_c0_stall", 32'(stall_f_o), 32'd1);
        tick();
        clr_in();
        chk("ld2_c1_state", 32'(state_o), 32'd1);
        chk("ld2_c1_outs", 32'(outs()), 32'b11001);
        tick();
        chk("ld2_c2_state", 32'(state_o), 32'd0);
        chk("ld2_c2_stall", 32'(stall_f_o), 32'd0);
        chk("ld2_cnt", 32'(stall_cnt_o), 32'd2);

        // Multicycle op completing after 5 wait cycles.
        do_reset();
        mc_start_i = 1'b1;
        tick();
        clr_in();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mc_wait%0d_se", i), 32'(stall_e_o), 32'd1);
            tick();
        end
        mc_done_i = 1'b1;
        #1;
        chk("mc_done_outs", 32'(outs()), 32'h0);
        tick();
        clr_in();
        chk("mc_done_state", 32'(state_o), 32'd0);
        chk("mc_done_tmo", 32'(mc_timeout_o), 32'd0);
        chk("mc_done_cnt", 32'(stall_cnt_o), 32'd5);

        // Timeout twice back to back: second run needs a freshly cleared watchdog.
        for (int r = 0; r < 2; r++) begin
            mc_start_i = 1'b1;
            tick();
            clr_in();
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("tmo%0d_wait%0d", r, i), 32'(state_o), 32'd2);
                tick();
            end
            chk($sformatf("tmo%0d_state", r), 32'(state_o), 32'd0);
            chk($sformatf("tmo%0d_flag", r), 32'(mc_timeout_o), 32'd1);
        end
        ld_stall_1clk_i = 1'b1;
        tick();
        clr_in();
        tick();
        chk("tmo_sticky", 32'(mc_timeout_o), 32'd1);
        do_reset();
        chk("tmo_cleared", 32'(mc_timeout_o), 32'd0);

        // Halt for 10 cycles, ignoring events while halted.
        do_reset();
        halt_req_i = 1'b1;
        tick();
        clr_in();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                redirect_i = 1'b1;
                mc_start_i = 1'b1;
                ld_stall_2clk_i = 1'b1;
            end
            #1;
            chk($sformatf("halt%0d_state", i), 32'(state_o), 32'd3);
            chk($sformatf("halt%0d_outs", i), 32'(outs()), 32'b11001);
            tick();
            clr_in();
        end
        resume_i = 1'b1;
        tick();
        clr_in();
        chk("resume_state", 32'(state_o), 32'd0);
        chk("halt_cnt", 32'(stall_cnt_o), 32'd11);

        // Reset mid-HALT abandons it.
        halt_req_i = 1'b1;
        tick();
        clr_in();
        chk("halt2_state", 32'(state_o), 32'd3);
        rst_i = 1'b1;
        #1;
        chk("halt2_rst_outs", 32'(outs()), 32'h0);
        tick();
        rst_i = 1'b0;
        chk("halt2_rst_state", 32'(state_o), 32'd0);
        chk("halt2_rst_cnt", 32'(stall_cnt_o), 32'd0);

        // Reset mid-MC_WAIT abandons it.
        mc_start_i = 1'b1;
        tick();
        clr_in();
        tick();
        do_reset();
        chk("mcrst_state", 32'(state_o), 32'd0);
        #1;
        chk("mcrst_outs", 32'(outs()), 32'h0);

        // Counter saturation with a 4-bit counter.
        do_reset();
        ld_stall_1clk_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) chk("sat_cnt14", 32'(stall_cnt_o), 32'd14);
        end
        clr_in();
        chk("sat_cnt", 32'(stall_cnt_o), 32'd15);
        chk("sat_state", 32'(state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_ctrl

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MC_TIMEOUT, default 64, SHALL set the maximum wait in cycles for a multicycle unit result.
REQ-002 Parameter CNT_W, default 16, SHALL set the stall performance counter width.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-005 ld_stall_2clk_i  in  1  SHALL indicate a load-use hazard with the load in execute (two stall cycles needed).
REQ-006 ld_stall_1clk_i  in  1  SHALL indicate a load-use hazard with the load in memory (one stall cycle needed).
REQ-007 redirect_i  in  1  SHALL indicate a branch/jump redirect resolved in execute this cycle.
REQ-008 mc_start_i  in  1  SHALL indicate a multicycle (mul/div) operation issuing in execute this cycle.
REQ-009 mc_done_i  in  1  SHALL indicate the multicycle result is valid this cycle.
REQ-010 halt_req_i / resume_i  in  1 each  SHALL request a pipeline halt / its release.
REQ-011 stall_f_o, stall_d_o, stall_e_o  out  1 each  SHALL hold the fetch, decode and execute pipeline registers.
REQ-012 flush_d_o  out  1  SHALL clear the fetch->decode register; bubble_e_o  out  1  SHALL load a bubble into the decode->execute register.
REQ-013 state_o  out  2  SHALL expose the FSM state (RUN=0, LD_WAIT=1, MC_WAIT=2, HALT=3).
REQ-014 mc_timeout_o  out  1  SHALL be a sticky multicycle timeout flag; stall_cnt_o  out  CNT_W  SHALL count stall cycles.

Function
REQ-015 All stall/flush/bubble outputs SHALL be combinational from current state and inputs (same-cycle response).
REQ-016 RUN, redirect_i=1: flush_d_o=1, bubble_e_o=1, no stall; ld_stall_* SHALL be ignored that cycle (wrong path).
REQ-017 RUN, no redirect, ld_stall_2clk_i=1: stall_f_o=stall_d_o=1, bubble_e_o=1; next state LD_WAIT.
REQ-018 RUN, no redirect, ld_stall_1clk_i=1 only: stall_f_o=stall_d_o=1, bubble_e_o=1 for that cycle; stay RUN.
REQ-019 RUN, mc_start_i=1: next state MC_WAIT (also when redirect_i=1; the op itself is not flushed); mc_start_i SHALL take priority over ld_stall_2clk_i for the next-state decision while the REQ-017 stall outputs still apply this cycle.
REQ-020 RUN, halt_req_i=1 with no other event: next state HALT; otherwise halt_req_i SHALL be re-sampled in a later RUN cycle.
REQ-021 LD_WAIT: stall_f_o=stall_d_o=1, bubble_e_o=1 for exactly one cycle; next state RUN unconditionally.
REQ-022 MC_WAIT, mc_done_i=0: stall_f_o=stall_d_o=stall_e_o=1, watchdog increments; mc_done_i=1: no stall that cycle, next state RUN.
REQ-023 MC_WAIT, watchdog reaching MC_TIMEOUT-1 without mc_done_i: mc_timeout_o SHALL set and remain set until reset; next state RUN.
REQ-024 HALT: stall_f_o=stall_d_o=1, bubble_e_o=1; resume_i=1 SHALL return to RUN next cycle; redirect_i, ld_stall_*, mc_start_i ignored.
REQ-025 Watchdog SHALL clear on every entry to MC_WAIT; width SHALL be clog2(MC_TIMEOUT).
REQ-026 stall_cnt_o SHALL increment each cycle stall_f_o=1 and SHALL saturate at all-ones.

Reset
REQ-027 With rst_i=1 at a clock edge: state RUN, watchdog 0, mc_timeout_o=0, stall_cnt_o=0.
REQ-028 During rst_i=1 all stall/flush/bubble outputs SHALL be 0; reset in any state (including mid-MC_WAIT or HALT) SHALL abandon it.

Structure
REQ-029 State encodings and MC_TIMEOUT default SHALL live in the shared pipeline package.
REQ-030 The block SHALL be a single FSM module; the saturating perf counter MAY be sub-module sat_counter.

Verification
REQ-031 ld_stall_2clk_i=1 in RUN for one cycle -> stall_f_o=1 for 2 consecutive cycles, state RUN->LD_WAIT->RUN, stall_cnt_o=2.
REQ-032 redirect_i=1 with ld_stall_2clk_i=1 -> flush_d_o=1, bubble_e_o=1, stall_f_o=0, state stays RUN.
REQ-033 mc_start_i=1, mc_done_i after 5 cycles -> stall_e_o=1 for 5 cycles, 0 on done cycle, then RUN.
REQ-034 mc_start_i=1, no mc_done_i, MC_TIMEOUT=8 -> RUN after 8 cycles, mc_timeout_o=1 until reset.
REQ-035 halt_req_i=1, resume_i after 10 cycles -> HALT for 10 cycles; rst_i pulse mid-HALT -> RUN, all counters 0.
REQ-036 CNT_W=4, 20 stall cycles -> stall_cnt_o saturates at 15.
